ahb_rr_arbiter: RTL and testbench
=================================

# ahb_rr_arbiter

Parameterised round-robin arbiter for the AHB-Lite-style system bus, sharing one bus among `NUM_MASTERS` requesters (core IF/LSU, DMA, debug). It produces registered one-hot grants and the `hmaster` and `hmastlock` selects that drive the address/control mux. Grant hand-over is held off across fixed-length bursts and locked sequences. It replaces the two-master fixed-priority arbiter wherever more than two masters share a bus.

## Interface
- `NUM_MASTERS`, default 4: number of requesters, 2..16.
- `DEFAULT_MASTER`, default 0: index granted (bus parking) when nobody requests; also the reset owner.
- `MW`, default `$clog2(NUM_MASTERS)`: width of `hmaster`; derived, not overridden.

Ports:
- `clk`  in  1  single bus clock; all state on rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `hbusreq`  in  NUM_MASTERS  per-master bus request.
- `hlock`  in  NUM_MASTERS  per-master locked-transfer request.
- `htrans`  in  2  transfer type of current address phase (muxed from owner); IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `hburst`  in  3  burst type of current address phase; SINGLE=0, INCR=1, WRAP4/INCR4=2/3, WRAP8/INCR8=4/5, WRAP16/INCR16=6/7.
- `hready`  in  1  bus ready from slave mux.
- `hgrant`  out  NUM_MASTERS  registered one-hot grant.
- `hmaster`  out  MW  index of the master owning the address phase.
- `hmastlock`  out  1  current address phase is part of a locked sequence.

## Operation
- Reset values: `hgrant` = one-hot(DEFAULT_MASTER), `hmaster` = DEFAULT_MASTER, `hmastlock` = 0, internal `beats_left` = 0.
- `hgrant` is always exactly one-hot; it is never all-zero.
- Burst tracker (5-bit `beats_left`) updates only on edges with `hready`=1:
  - NONSEQ: set to 3, 7 or 15 for the 4-, 8- and 16-beat bursts; set to 0 for SINGLE or INCR.
  - SEQ: decrement if nonzero, saturating at 0.
  - IDLE: clear to 0, so an early-terminated burst releases the bus.
  - BUSY: hold.
- `beats_left_nxt` is the value the tracker takes on the current edge.
- `locked` = `hlock[gidx] | hmastlock`, where `gidx` is the index of the current `hgrant`.
- `arb_ok` = `hready` & !`locked` & (`beats_left_nxt` == 0).
- Winner selection: scan indices gidx+1, gidx+2, …, gidx+N (mod N); the first index with `hbusreq` set wins.
  - The current owner is therefore considered last.
  - If no request is set, the winner is DEFAULT_MASTER.
- On edges with `arb_ok`=1, `hgrant` <= one-hot(winner). Otherwise `hgrant` holds.
- On edges with `hready`=1:
  - `hmaster` <= gidx.
  - `hmastlock` <= `hlock[gidx]`.
  - With `hready`=0 both hold.
- SINGLE or INCR traffic re-arbitrates on every accepted transfer. This gives fair round-robin at transfer granularity.

## Timing
- Request to grant: `hbusreq[i]` seen before edge E with `arb_ok`=1 gives `hgrant[i]`=1 after E.
- Grant to ownership: `hmaster`=i after the next `hready`=1 edge. Minimum latency is 2 edges.
- Wait states (`hready`=0) freeze `hgrant`, `hmaster`, `hmastlock` and `beats_left`.
- Fixed burst: grant may move only on the edge accepting the last SEQ (`beats_left_nxt`=0). The new owner's NONSEQ follows after one `hmaster` update edge.
- Lock: grant is held while `hlock[owner]`=1. It is also held one further `hready` edge after `hlock` drops, because `hmastlock` is still 1. It may move on the following `arb_ok` edge.
- Simultaneous requests: the winner is strictly determined by the rotating scan; there is no priority beyond it.
- Owner deasserts `hbusreq` with no other requester: grant parks on DEFAULT_MASTER at the next `arb_ok` edge.
- `rstn` low at any time, including mid-burst or mid-lock: all state returns to reset values immediately. The in-flight burst is abandoned.

## Test plan
- Reset: assert `rstn`=0 mid-INCR8 of master 2 → `hgrant`=4'b0001, `hmaster`=0, `hmastlock`=0 asynchronously; after release with no requests, values hold.
- Single requester: `hbusreq`=4'b0100, `hready`=1, `htrans`=IDLE → `hgrant`=4'b0100 after edge 1, `hmaster`=2 after edge 2.
- Round-robin: `hbusreq`=4'b1111, SINGLE NONSEQ each cycle, `hready`=1 → `hgrant` sequence 0010, 0100, 1000, 0001, 0010; `hmaster` trails by one edge.
- Burst hold: master 1 owns the bus and issues INCR4 (NONSEQ, SEQ×3) with `hbusreq`=4'b1010 → `hgrant` stays 4'b0010 until the edge accepting the 3rd SEQ, then becomes 4'b1000. Insert `hready`=0 for 2 cycles mid-burst → no change during the stall.
- Early termination: INCR16 NONSEQ, 2 SEQ, then IDLE → grant moves on the IDLE edge.
- Lock: master 0 drives `hlock`=1 for 5 transfers while masters 1–3 request → `hgrant`=4'b0001 and `hmastlock`=1 throughout. `hmastlock` returns to 0 one `hready` edge after `hlock` drops; `hgrant` becomes 4'b0010 on the next edge.

Source files
------------

// File: rtl/ahb_rr_arbiter.sv
`default_nettype none
// ahb_rr_arbiter: round-robin AHB-Lite bus arbiter that holds the grant across fixed bursts and locked sequences.
// Revision: 1.0
module ahb_rr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic                   hmastlock
);

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  logic [4:0]               beats_left;
  logic [4:0]               beats_left_nxt;
  logic [MW-1:0]            gidx;
  logic [MW-1:0]            winner;
  logic [2*NUM_MASTERS-1:0] req_dbl;
  logic [NUM_MASTERS-1:0]   req_rot;
  logic                     locked;
  logic                     arb_ok;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (hgrant[i]) gidx = MW'(i);
  end

  always_comb begin
    beats_left_nxt = beats_left;
    if (hready) begin
      case (htrans)
        TR_NONSEQ: begin
          case (hburst)
            3'd2, 3'd3: beats_left_nxt = 5'd3;
            3'd4, 3'd5: beats_left_nxt = 5'd7;
            3'd6, 3'd7: beats_left_nxt = 5'd15;
            default:    beats_left_nxt = 5'd0;
          endcase
        end
        TR_SEQ:  if (beats_left != 5'd0) beats_left_nxt = beats_left - 5'd1;
        TR_IDLE: beats_left_nxt = 5'd0;
        default: beats_left_nxt = beats_left;
      endcase
    end
  end

  assign locked = hlock[gidx] | hmastlock;
  assign arb_ok = hready & ~locked & (beats_left_nxt == 5'd0);

  // req_rot[j] is the request of master (gidx+1+j) mod N, so the owner sits last.
  assign req_dbl = {hbusreq, hbusreq};
  assign req_rot = NUM_MASTERS'(req_dbl >> (32'(gidx) + 32'd1));

  always_comb begin
    winner = MW'(DEFAULT_MASTER);
    for (int j = NUM_MASTERS - 1; j >= 0; j--)
      if (req_rot[j]) winner = MW'((int'(gidx) + 1 + j) % NUM_MASTERS);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hgrant     <= NUM_MASTERS'(1) << DEFAULT_MASTER;
      hmaster    <= MW'(DEFAULT_MASTER);
      hmastlock  <= 1'b0;
      beats_left <= 5'd0;
    end else begin
      if (hready) begin
        beats_left <= beats_left_nxt;
        hmaster    <= gidx;
        hmastlock  <= hlock[gidx];
      end
      if (arb_ok)
        hgrant <= NUM_MASTERS'(1) << winner;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_rr_arbiter.sv
`default_nettype none
// tb_ahb_rr_arbiter: directed and randomized checks of ahb_rr_arbiter against a behavioural model.
// Revision: 1.0
module tb_ahb_rr_arbiter;

  localparam int N   = 4;
  localparam int DEF = 0;

  logic         clk;
  logic         rstn;
  logic [N-1:0] hbusreq;
  logic [N-1:0] hlock;
  logic [1:0]   htrans;
  logic [2:0]   hburst;
  logic         hready;
  logic [N-1:0] hgrant;
  logic [1:0]   hmaster;
  logic         hmastlock;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state: owner index, address-phase master, lock flag, beats still owed.
  int m_g, m_mst, m_lk, m_beats;

  ahb_rr_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
    .clk(clk), .rstn(rstn), .hbusreq(hbusreq), .hlock(hlock), .htrans(htrans),
    .hburst(hburst), .hready(hready), .hgrant(hgrant), .hmaster(hmaster),
    .hmastlock(hmastlock)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ":hgrant"},    32'(hgrant),    32'(1) << m_g);
    check({tag, ":hmaster"},   32'(hmaster),   32'(m_mst));
    check({tag, ":hmastlock"}, 32'(hmastlock), 32'(m_lk));
  endtask

  function automatic int burst_beats(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_g = DEF; m_mst = DEF; m_lk = 0; m_beats = 0;
  endtask

  task automatic step(input string tag);
    int  b_n, g_n, mst_n, lk_n, cand;
    bit  found;
    b_n = m_beats; g_n = m_g; mst_n = m_mst; lk_n = m_lk;
    if (hready) begin
      case (htrans)
        2'd0: b_n = 0;
        2'd2: b_n = burst_beats(hburst) - 1;
        2'd3: b_n = (m_beats > 0) ? m_beats - 1 : 0;
        default: b_n = m_beats;
      endcase
    end
    if (hready && !(hlock[m_g] || (m_lk != 0)) && b_n == 0) begin
      g_n = DEF;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        cand = (m_g + k) % N;
        if (!found && hbusreq[cand]) begin
          g_n = cand;
          found = 1'b1;
        end
      end
    end
    if (hready) begin
      mst_n = m_g;
      lk_n  = hlock[m_g] ? 1 : 0;
    end
    @(posedge clk);
    #1;
    m_beats = b_n; m_g = g_n; m_mst = mst_n; m_lk = lk_n;
    check_model(tag);
  endtask

  task automatic areset(input string tag);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_model(tag);
    check({tag, ":grant_const"}, 32'(hgrant), 32'h1);
    #1 rstn = 1'b1;
  endtask

  initial begin
    logic [3:0] rr_grant [5];
    int         rr_mst   [5];
    rr_grant = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    rr_mst   = '{0, 1, 2, 3, 0};

    rstn = 1'b0; hbusreq = '0; hlock = '0; htrans = 2'd0; hburst = 3'd0; hready = 1'b1;
    model_reset();
    #12;
    check_model("reset");
    check("reset:grant_const", 32'(hgrant), 32'h1);
    #1 rstn = 1'b1;

    // Single requester
    hbusreq = 4'b0100;
    step("single_e1");
    check("single_e1:grant", 32'(hgrant), 32'h4);
    step("single_e2");
    check("single_e2:master", 32'(hmaster), 32'd2);

    // Round-robin on SINGLE transfers
    areset("rr_reset");
    hbusreq = 4'b1111; htrans = 2'd2; hburst = 3'd0;
    for (int i = 0; i < 5; i++) begin
      step("rr");
      check("rr:grant", 32'(hgrant), 32'(rr_grant[i]));
      check("rr:master", 32'(hmaster), 32'(rr_mst[i]));
    end

    // INCR4 burst hold with a two-cycle stall
    areset("burst_reset");
    hbusreq = 4'b0010; htrans = 2'd0;
    step("burst_own");
    hbusreq = 4'b1010; htrans = 2'd2; hburst = 3'd3;
    step("burst_nonseq");
    check("burst_nonseq:grant", 32'(hgrant), 32'h2);
    htrans = 2'd3;
    step("burst_seq1");
    hready = 1'b0;
    step("burst_stall1");
    step("burst_stall2");
    check("burst_stall:grant", 32'(hgrant), 32'h2);
    hready = 1'b1;
    step("burst_seq2");
    check("burst_seq2:grant", 32'(hgrant), 32'h2);
    step("burst_seq3");
    check("burst_seq3:grant", 32'(hgrant), 32'h8);

    // INCR16 terminated early by IDLE
    htrans = 2'd2; hburst = 3'd7;
    step("early_nonseq");
    htrans = 2'd3;
    step("early_seq1");
    step("early_seq2");
    check("early_seq2:grant", 32'(hgrant), 32'h8);
    htrans = 2'd0;
    step("early_idle");
    check("early_idle:grant", 32'(hgrant), 32'h2);

    // Locked sequence by master 0
    areset("lock_reset");
    hbusreq = 4'b1111; hlock = 4'b0001; htrans = 2'd2; hburst = 3'd0;
    for (int i = 0; i < 5; i++) begin
      step("lock_hold");
      check("lock_hold:grant", 32'(hgrant), 32'h1);
      check("lock_hold:mastlock", 32'(hmastlock), 32'd1);
    end
    hlock = 4'b0000;
    step("lock_drop");
    check("lock_drop:mastlock", 32'(hmastlock), 32'd0);
    check("lock_drop:grant", 32'(hgrant), 32'h1);
    step("lock_release");
    check("lock_release:grant", 32'(hgrant), 32'h2);

    // Reset in the middle of an INCR8 owned by master 2
    areset("mid_reset_pre");
    hbusreq = 4'b0100; htrans = 2'd0;
    step("mid_own");
    htrans = 2'd2; hburst = 3'd5;
    step("mid_nonseq");
    htrans = 2'd3;
    step("mid_seq");
    areset("mid_reset");
    check("mid_reset:master", 32'(hmaster), 32'd0);
    check("mid_reset:mastlock", 32'(hmastlock), 32'd0);
    hbusreq = 4'b0000; htrans = 2'd0;
    step("post_reset1");
    step("post_reset2");
    check("post_reset:grant", 32'(hgrant), 32'h1);
    check("post_reset:master", 32'(hmaster), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      hbusreq = 4'($urandom);
      hlock   = 4'($urandom & $urandom & $urandom);
      htrans  = 2'($urandom);
      hburst  = 3'($urandom);
      hready  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) areset("rand_reset");
      step("rand");
      check("rand:onehot", 32'($onehot(hgrant)), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
